pc_fetch_sequencer: RTL and testbench

//  Hack CPU program counter plus instruction-fetch sequencer. Holds PC and presents it to instruction ROM

---
 rtl/hack_pkg.sv | 24 ++
 rtl/pc_fetch_sequencer_incrementor16.sv | 13 +
 rtl/pc_fetch_sequencer.sv | 132 +++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared types and defaults for the Hack fetch path.
//   seqState_t : sequencer states (IDLE / FETCH / HALT)
//   HACK_*     : default widths and ROM depth
//   satInc     : saturating increment for counters up to 32 bits wide
package hack_pkg;

    localparam int unsigned HACK_PC_W      = 16;
    localparam int unsigned HACK_ROM_DEPTH = 32768;
    localparam int unsigned HACK_CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } seqState_t;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [31:0] satInc(input logic [31:0] v, input int unsigned w);
        logic [31:0] maxVal;
        maxVal = 32'hFFFF_FFFF >> (32 - w);
        return (v == maxVal) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_incrementor16.sv
// PC incrementor.
//   a : current value
//   y : a + 1 (wraps at 2**W)
module Incrementor16 #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);

    assign y = a + W'(1);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Hack program counter and instruction-fetch sequencer.
//   clk, reset  : clock, synchronous active-high reset
//   run_en      : fetching permitted
//   jump        : take jump_addr on the handshake cycle
//   jump_addr   : jump target
//   fetch_ready : ROM accepts current address
//   pc          : current fetch address
//   fetch_valid : pc is a valid fetch request
//   halted      : sequencer in HALT
//   addr_err    : halt caused by out-of-range jump target
//   retired_cnt : accepted fetches (saturating)
//   stall_cnt   : cycles with valid & !ready (saturating)
import hack_pkg::*;

module pc_fetch_sequencer #(
    parameter int unsigned PC_W      = HACK_PC_W,
    parameter int unsigned ROM_DEPTH = HACK_ROM_DEPTH,
    parameter int unsigned CNT_W     = HACK_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_en,
    input  logic             jump,
    input  logic [PC_W-1:0]  jump_addr,
    input  logic             fetch_ready,
    output logic [PC_W-1:0]  pc,
    output logic             fetch_valid,
    output logic             halted,
    output logic             addr_err,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [PC_W:0]   ROM_DEPTH_EXT = (PC_W+1)'(ROM_DEPTH);
    localparam logic [PC_W-1:0] LAST_ADDR     = PC_W'(ROM_DEPTH - 1);

    seqState_t        state;
    seqState_t        nextState;
    logic [PC_W-1:0]  pcPlusOne;
    logic [PC_W-1:0]  pcNext;
    logic             fetchValidNext;
    logic             haltedNext;
    logic             addrErrNext;
    logic [CNT_W-1:0] retiredNext;
    logic [CNT_W-1:0] stallNext;
    logic             handshake;
    logic             jumpOutOfRange;
    logic             jumpSelf;

    Incrementor16 #(.W(PC_W)) uInc (
        .a (pc),
        .y (pcPlusOne)
    );

    assign handshake      = fetch_valid & fetch_ready;
    assign jumpOutOfRange = ({1'b0, jump_addr} >= ROM_DEPTH_EXT);
    assign jumpSelf       = (jump_addr == pc);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; a request always completes before leaving FETCH.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (run_en) nextState = FETCH;
            end
            FETCH: begin
                if (handshake) begin
                    if (jump && (jumpOutOfRange || jumpSelf)) nextState = HALT;
                    else if (run_en)                          nextState = FETCH;
                    else                                      nextState = IDLE;
                end
            end
            HALT:    nextState = HALT;
            default: nextState = IDLE;
        endcase
    end

    // Output/datapath next values; all registered below.
    always_comb begin
        pcNext         = pc;
        addrErrNext    = addr_err;
        retiredNext    = retired_cnt;
        stallNext      = stall_cnt;
        fetchValidNext = (nextState == FETCH);
        haltedNext     = (nextState == HALT);
        if (state == FETCH) begin
            if (handshake) begin
                retiredNext = CNT_W'(satInc(32'(retired_cnt), CNT_W));
                if (jump && jumpOutOfRange) begin
                    addrErrNext = 1'b1;
                end else if (jump && jumpSelf) begin
                    pcNext = pc;
                end else if (jump) begin
                    pcNext = jump_addr;
                end else begin
                    pcNext = (pc == LAST_ADDR) ? '0 : pcPlusOne;
                end
            end else if (fetch_valid) begin
                stallNext = CNT_W'(satInc(32'(stall_cnt), CNT_W));
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= '0;
            fetch_valid <= 1'b0;
            halted      <= 1'b0;
            addr_err    <= 1'b0;
            retired_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            pc          <= pcNext;
            fetch_valid <= fetchValidNext;
            halted      <= haltedNext;
            addr_err    <= addrErrNext;
            retired_cnt <= retiredNext;
            stall_cnt   <= stallNext;
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: sequential fetch, stalls, wrap,
// halt idiom, out-of-range jump, run_en drop and reset recovery.
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_en;
    logic        jump;
    logic [15:0] jump_addr;
    logic        fetch_ready;
    logic [15:0] pc;
    logic        fetch_valid;
    logic        halted;
    logic        addr_err;
    logic [15:0] retired_cnt;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    pc_fetch_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .run_en      (run_en),
        .jump        (jump),
        .jump_addr   (jump_addr),
        .fetch_ready (fetch_ready),
        .pc          (pc),
        .fetch_valid (fetch_valid),
        .halted      (halted),
        .addr_err    (addr_err),
        .retired_cnt (retired_cnt),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample/drive 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chkAll(input string tag, input logic [15:0] ePc, input logic eV,
                          input logic eH, input logic eE, input logic [15:0] eR,
                          input logic [15:0] eS);
        chk({tag, ".pc"},      32'(pc),          32'(ePc));
        chk({tag, ".valid"},   32'(fetch_valid), 32'(eV));
        chk({tag, ".halted"},  32'(halted),      32'(eH));
        chk({tag, ".addrerr"}, 32'(addr_err),    32'(eE));
        chk({tag, ".retired"}, 32'(retired_cnt), 32'(eR));
        chk({tag, ".stall"},   32'(stall_cnt),   32'(eS));
    endtask

    initial begin
        reset = 1'b1; run_en = 1'b0; jump = 1'b0; jump_addr = '0; fetch_ready = 1'b0;
        tick(); tick();
        chkAll("reset", 16'h0, 0, 0, 0, 0, 0);

        // Back-to-back fetches.
        reset = 1'b0; run_en = 1'b1; fetch_ready = 1'b1;
        tick();
        chk("t1.valid_rise", 32'(fetch_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1.pc%0d", i), 32'(pc), 32'(i));
            tick();
        end
        chkAll("t1.end", 16'h4, 1, 0, 0, 4, 0);

        // Stall at pc=5.
        tick();
        chk("t2.pc5", 32'(pc), 32'h5);
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t2.stall_pc%0d", i), 32'(pc), 32'h5);
            chk($sformatf("t2.stall_v%0d", i), 32'(fetch_valid), 32'd1);
        end
        chk("t2.stallcnt", 32'(stall_cnt), 32'd3);
        fetch_ready = 1'b1;
        tick();
        chkAll("t2.resume", 16'h6, 1, 0, 0, 6, 3);

        // Wrap at last ROM address.
        jump = 1'b1; jump_addr = 16'h7FFF;
        tick();
        chk("t3.pc7fff", 32'(pc), 32'h7FFF);
        jump = 1'b0;
        tick();
        chkAll("t3.wrap", 16'h0, 1, 0, 0, 8, 3);

        // Jump during stall is ignored.
        fetch_ready = 1'b0; jump = 1'b1; jump_addr = 16'h8000;
        tick(); tick();
        chkAll("t5.stalljump", 16'h0, 1, 0, 0, 8, 5);

        // Halt idiom at 0x0010.
        jump_addr = 16'h0010; fetch_ready = 1'b1;
        tick();
        chk("t4.pc10", 32'(pc), 32'h10);
        tick();
        chkAll("t4.halt", 16'h10, 0, 1, 0, 10, 5);
        jump_addr = 16'h0003;
        tick(); tick();
        chkAll("t4.frozen", 16'h10, 0, 1, 0, 10, 5);

        // Reset out of HALT.
        reset = 1'b1; jump = 1'b0;
        tick();
        chkAll("t6.reset_halt", 16'h0, 0, 0, 0, 0, 0);

        // Out-of-range jump.
        reset = 1'b0; run_en = 1'b1; fetch_ready = 1'b1;
        tick();
        chk("t5.valid", 32'(fetch_valid), 32'd1);
        jump = 1'b1; jump_addr = 16'h8000;
        tick();
        chkAll("t5.oor", 16'h0, 0, 1, 1, 1, 0);

        // run_en drop during stall finishes the request.
        reset = 1'b1; jump = 1'b0;
        tick();
        reset = 1'b0; run_en = 1'b1; fetch_ready = 1'b0;
        tick();
        chk("t6.valid", 32'(fetch_valid), 32'd1);
        tick();
        chk("t6.stall1", 32'(stall_cnt), 32'd1);
        run_en = 1'b0;
        tick();
        chkAll("t6.hold", 16'h0, 1, 0, 0, 0, 2);
        fetch_ready = 1'b1;
        tick();
        chkAll("t6.done", 16'h1, 0, 0, 0, 1, 2);
        tick();
        chkAll("t6.idle", 16'h1, 0, 0, 0, 1, 2);

        // Reset mid-stall drops the request.
        run_en = 1'b1; fetch_ready = 1'b0;
        tick(); tick();
        chk("t6.midstall_v", 32'(fetch_valid), 32'd1);
        reset = 1'b1;
        tick();
        chkAll("t6.midstall_rst", 16'h0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
